// File: rtl/matmul_stream_ctrl.sv
// Sequencing controller for the matrix-multiply stream coprocessor.
// It receives A then B over the input stream into the A/B RAMs, runs the
// i/j/k MAC schedule against those RAMs, and streams the RES RAM out.
// Data lanes never pass through here; only addresses, enables and handshakes do.
module matmul_stream_ctrl #(
    parameter int A_ROWS = 2,
    parameter int A_COLS = 4,
    parameter int B_COLS = 1,
    parameter int A_AW   = 3,
    parameter int B_AW   = 2,
    parameter int R_AW   = 1
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            S_AXIS_TVALID,
    input  logic            S_AXIS_TLAST,
    output logic            S_AXIS_TREADY,
    input  logic            M_AXIS_TREADY,
    output logic            M_AXIS_TVALID,
    output logic            M_AXIS_TLAST,
    output logic            A_we,
    output logic [A_AW-1:0] A_addr,
    output logic            B_we,
    output logic [B_AW-1:0] B_addr,
    output logic            mac_en,
    output logic            mac_first,
    output logic            R_we,
    output logic [R_AW-1:0] R_waddr,
    output logic [R_AW-1:0] R_raddr,
    output logic            busy,
    output logic            done,
    output logic            tlast_err
);

    localparam int NA  = A_ROWS * A_COLS;
    localparam int NB  = A_COLS * B_COLS;
    localparam int NIN = NA + NB;
    localparam int NR  = A_ROWS * B_COLS;
    localparam int WW  = $clog2(NIN + 1);
    localparam int IW  = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
    localparam int JW  = (B_COLS > 1) ? $clog2(B_COLS) : 1;
    localparam int KW  = (A_COLS > 1) ? $clog2(A_COLS) : 1;

    localparam logic [WW-1:0]   NA_W     = WW'(NA);
    localparam logic [WW-1:0]   W_LAST   = WW'(NIN - 1);
    localparam logic [IW-1:0]   I_LAST   = IW'(A_ROWS - 1);
    localparam logic [JW-1:0]   J_LAST   = JW'(B_COLS - 1);
    localparam logic [KW-1:0]   K_LAST   = KW'(A_COLS - 1);
    localparam logic [R_AW-1:0] O_LAST   = R_AW'(NR - 1);
    localparam logic [A_AW-1:0] A_STRIDE = A_AW'(A_COLS);
    localparam logic [B_AW-1:0] B_STRIDE = B_AW'(B_COLS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN1  = 3'd3,
        S_DRAIN2  = 3'd4,
        S_FETCH   = 3'd5,
        S_TX      = 3'd6
    } state_t;

    state_t          state_q;
    logic [WW-1:0]   w_q;
    logic [IW-1:0]   i_q;
    logic [JW-1:0]   j_q;
    logic [KW-1:0]   k_q;
    logic [A_AW-1:0] a_ptr_q;    // i*A_COLS + k
    logic [A_AW-1:0] a_row_q;    // i*A_COLS
    logic [B_AW-1:0] b_ptr_q;    // k*B_COLS + j
    logic [R_AW-1:0] r_idx_q;    // i*B_COLS + j
    logic [R_AW-1:0] o_q;
    logic            tready_q;
    logic            tvalid_q;
    logic            tlast_q;
    logic            busy_q;
    logic            tlast_err_q;
    logic            s1_en_q;
    logic            s1_first_q;
    logic            s1_last_q;
    logic [R_AW-1:0] s1_widx_q;
    logic            r_we_q;
    logic [R_AW-1:0] r_waddr_q;

    logic            s_hs_s;
    logic            m_hs_s;
    logic            in_a_s;
    logic            issue_s;
    logic [WW-1:0]   w_b_s;

    assign s_hs_s  = tready_q & S_AXIS_TVALID;
    assign m_hs_s  = tvalid_q & M_AXIS_TREADY;
    assign in_a_s  = (w_q < NA_W);
    assign issue_s = (state_q == S_COMPUTE);
    assign w_b_s   = w_q - NA_W;

    // Write enables follow the input handshake within the same cycle so the
    // RAM captures TDATA on the handshake edge.
    assign A_we   = s_hs_s & in_a_s;
    assign B_we   = s_hs_s & ~in_a_s;
    assign A_addr = (state_q == S_RECV) ? A_AW'(w_q)   : a_ptr_q;
    assign B_addr = (state_q == S_RECV) ? B_AW'(w_b_s) : b_ptr_q;

    assign S_AXIS_TREADY = tready_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign R_raddr       = o_q;
    assign busy          = busy_q;
    assign tlast_err     = tlast_err_q;
    assign done          = m_hs_s & tlast_q;
    assign mac_en        = s1_en_q;
    assign mac_first     = s1_first_q;
    assign R_we          = r_we_q;
    assign R_waddr       = r_waddr_q;

    // Main sequencer: state, receive/issue/output counters and registered handshake outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            w_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            a_ptr_q     <= '0;
            a_row_q     <= '0;
            b_ptr_q     <= '0;
            r_idx_q     <= '0;
            o_q         <= '0;
            tready_q    <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            tlast_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q  <= S_RECV;
                    tready_q <= 1'b1;
                    w_q      <= '0;
                end
                S_RECV: begin
                    if (s_hs_s) begin
                        // TLAST only flags a framing error; it never steers the sequence.
                        if (S_AXIS_TLAST != (w_q == W_LAST)) begin
                            tlast_err_q <= 1'b1;
                        end
                        if (w_q == W_LAST) begin
                            state_q  <= S_COMPUTE;
                            tready_q <= 1'b0;
                            busy_q   <= 1'b1;
                            w_q      <= '0;
                            i_q      <= '0;
                            j_q      <= '0;
                            k_q      <= '0;
                            a_ptr_q  <= '0;
                            a_row_q  <= '0;
                            b_ptr_q  <= '0;
                            r_idx_q  <= '0;
                        end else begin
                            w_q <= w_q + WW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (k_q == K_LAST) begin
                        k_q     <= '0;
                        r_idx_q <= r_idx_q + R_AW'(1);
                        if (j_q == J_LAST) begin
                            j_q     <= '0;
                            i_q     <= i_q + IW'(1);
                            a_row_q <= a_row_q + A_STRIDE;
                            a_ptr_q <= a_row_q + A_STRIDE;
                            b_ptr_q <= '0;
                            if (i_q == I_LAST) begin
                                state_q <= S_DRAIN1;
                            end
                        end else begin
                            j_q     <= j_q + JW'(1);
                            a_ptr_q <= a_row_q;
                            b_ptr_q <= B_AW'(j_q) + B_AW'(1);
                        end
                    end else begin
                        k_q     <= k_q + KW'(1);
                        a_ptr_q <= a_ptr_q + A_AW'(1);
                        b_ptr_q <= b_ptr_q + B_STRIDE;
                    end
                end
                S_DRAIN1: begin
                    state_q <= S_DRAIN2;
                end
                S_DRAIN2: begin
                    state_q <= S_FETCH;
                    busy_q  <= 1'b0;
                end
                S_FETCH: begin
                    state_q  <= S_TX;
                    tvalid_q <= 1'b1;
                    tlast_q  <= (o_q == O_LAST);
                end
                S_TX: begin
                    if (m_hs_s) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        if (tlast_q) begin
                            state_q  <= S_RECV;
                            tready_q <= 1'b1;
                            o_q      <= '0;
                        end else begin
                            state_q <= S_FETCH;
                            o_q     <= o_q + R_AW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    tready_q <= 1'b0;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // MAC/RES pipeline: stage 1 matches the RAM read latency, stage 2 the accumulator register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            s1_en_q    <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_widx_q  <= '0;
            r_we_q     <= 1'b0;
            r_waddr_q  <= '0;
        end else begin
            s1_en_q    <= issue_s;
            s1_first_q <= issue_s & (k_q == KW'(0));
            s1_last_q  <= issue_s & (k_q == K_LAST);
            s1_widx_q  <= r_idx_q;
            r_we_q     <= s1_last_q;
            r_waddr_q  <= s1_widx_q;
        end
    end

endmodule
